// File: rtl/mssd_frame_tx_if.sv
// Parallel request / serial status bundle for the MSSD frame transmitter.
// The master side issues transmit requests; the slave side (the transmitter)
// drives the serial line and the frame status flags.
interface mssd_frame_tx_if #(
  parameter int PORT_W = 2,
  parameter int CNT_W  = 4
);
  localparam int DATA_W = (1 << CNT_W) - 1;

  logic              start;
  logic [PORT_W-1:0] port;
  logic [CNT_W-1:0]  NumData;
  logic [DATA_W-1:0] data_in;
  logic              serOut;
  logic              busy;
  logic              ready;
  logic              done;

  modport master (
    output start, port, NumData, data_in,
    input  serOut, busy, ready, done
  );

  modport slave (
    input  start, port, NumData, data_in,
    output serOut, busy, ready, done
  );
endinterface

// File: rtl/mssd_frame_tx.sv
// MSSD serial frame transmitter: start bit, port field (MSB first), count
// field (MSB first), then NumData payload bits from data_in[NumData-1] down
// to data_in[0]. All bit timing advances only on clkEn edges.
module mssd_frame_tx #(
  parameter int PORT_W = 2,
  parameter int CNT_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clkEn,
  mssd_frame_tx_if.slave bus
);
  localparam int DATA_W = (1 << CNT_W) - 1;

  typedef enum logic [2:0] {IDLE, START, PORT, NUM, DATA} state_t;

  state_t              state_q;
  logic [PORT_W-1:0]   port_q;
  logic [CNT_W-1:0]    num_q;
  logic [CNT_W-1:0]    num_sh_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic                ser_q;
  logic                busy_q;
  logic                done_q;
  logic [CNT_W-1:0]    align_d;

  // Payload is left-aligned on accept so data_in[NumData-1] sits at the MSB
  // and the DATA state can simply shift out of the top bit.
  assign align_d = CNT_W'(DATA_W) - bus.NumData;

  // Frame sequencer: one bit per clkEn edge; done is a single-clk pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      port_q   <= '0;
      num_q    <= '0;
      num_sh_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      ser_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clkEn) begin
        unique case (state_q)
          IDLE: begin
            ser_q <= 1'b1;
            if (bus.start) begin
              port_q   <= bus.port;
              num_q    <= bus.NumData;
              num_sh_q <= bus.NumData;
              data_q   <= bus.data_in << align_d;
              busy_q   <= 1'b1;
              ser_q    <= 1'b0;
              state_q  <= START;
            end
          end
          START: begin
            ser_q   <= port_q[PORT_W-1];
            port_q  <= port_q << 1;
            cnt_q   <= CNT_W'(PORT_W - 1);
            state_q <= PORT;
          end
          PORT: begin
            if (cnt_q == '0) begin
              ser_q    <= num_sh_q[CNT_W-1];
              num_sh_q <= num_sh_q << 1;
              cnt_q    <= CNT_W'(CNT_W - 1);
              state_q  <= NUM;
            end else begin
              ser_q  <= port_q[PORT_W-1];
              port_q <= port_q << 1;
              cnt_q  <= cnt_q - CNT_W'(1);
            end
          end
          NUM: begin
            if (cnt_q != '0) begin
              ser_q    <= num_sh_q[CNT_W-1];
              num_sh_q <= num_sh_q << 1;
              cnt_q    <= cnt_q - CNT_W'(1);
            end else if (num_q != '0) begin
              // Counter holds the number of payload bits still on the line,
              // including the one being driven now.
              cnt_q   <= num_q;
              ser_q   <= data_q[DATA_W-1];
              data_q  <= data_q << 1;
              state_q <= DATA;
            end else begin
              ser_q   <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          DATA: begin
            if (cnt_q == CNT_W'(1)) begin
              cnt_q   <= '0;
              ser_q   <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q  <= cnt_q - CNT_W'(1);
              ser_q  <= data_q[DATA_W-1];
              data_q <= data_q << 1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.serOut = ser_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ready  = ~busy_q;
endmodule

// File: tb/tb_mssd_frame_tx.sv
// Directed bench for mssd_frame_tx: expected serial bits are queued when a
// request is issued and popped bit-time by bit-time as the line is sampled.
module tb_mssd_frame_tx;
  localparam int PW = 2;
  localparam int CW = 4;
  localparam int DW = 15;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic clkEn = 1'b1;
  bit   alt   = 1'b0;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  mssd_frame_tx_if #(.PORT_W(PW), .CNT_W(CW)) bus_if ();

  mssd_frame_tx #(.PORT_W(PW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .clkEn (clkEn),
    .bus   (bus_if)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  // Advance one clock, land 1 time unit after the edge, set clkEn for next edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (alt) clkEn = ~clkEn;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ser"},   bus_if.serOut, 1'b1);
    chk({tag, "_busy"},  bus_if.busy,   1'b0);
    chk({tag, "_ready"}, bus_if.ready,  1'b1);
    chk({tag, "_done"},  bus_if.done,   1'b0);
  endtask

  task automatic push_frame(input logic [PW-1:0] p, input logic [CW-1:0] n,
                            input logic [DW-1:0] d);
    exp_q.push_back(1'b0);
    for (int i = PW - 1; i >= 0; i--) exp_q.push_back(p[i]);
    for (int i = CW - 1; i >= 0; i--) exp_q.push_back(n[i]);
    for (int i = int'(n) - 1; i >= 0; i--) exp_q.push_back(d[i]);
    exp_q.push_back(1'b1);
  endtask

  task automatic do_frame(input string tag, input logic [PW-1:0] p,
                          input logic [CW-1:0] n, input logic [DW-1:0] d,
                          input int per, input bit disturb);
    int   len;
    logic e;
    push_frame(p, n, d);
    len = 1 + PW + CW + int'(n);
    if (clkEn !== 1'b1) step();
    bus_if.start   = 1'b1;
    bus_if.port    = p;
    bus_if.NumData = n;
    bus_if.data_in = d;
    step();
    bus_if.start = 1'b0;
    for (int k = 0; k <= len; k++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < per; c++) begin
        if (disturb && k == 3 && c == 0) begin
          bus_if.start   = 1'b1;
          bus_if.port    = ~p;
          bus_if.NumData = 4'd15;
          bus_if.data_in = ~d;
        end
        if (disturb && k == 6 && c == 0) bus_if.start = 1'b0;
        chk($sformatf("%s_ser_b%0d_c%0d", tag, k, c),   bus_if.serOut, e);
        chk($sformatf("%s_busy_b%0d_c%0d", tag, k, c),  bus_if.busy,   k < len);
        chk($sformatf("%s_ready_b%0d_c%0d", tag, k, c), bus_if.ready,  k >= len);
        chk($sformatf("%s_done_b%0d_c%0d", tag, k, c),  bus_if.done,
            (k == len) && (c == 0));
        if (!(k == len && c == per - 1)) step();
      end
    end
    step();
    check_idle({tag, "_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.start   = 1'b1;
    bus_if.port    = '0;
    bus_if.NumData = '0;
    bus_if.data_in = '0;

    // Scenario 1: reset held with start asserted
    rst = 1'b0;
    step();
    check_idle("s1_rst0");
    step();
    check_idle("s1_rst1");
    bus_if.start = 1'b0;
    rst = 1'b1;
    step();
    check_idle("s1_rel");

    // Scenario 2: basic 3-bit payload, clkEn constant
    do_frame("s2", 2'b10, 4'd3, 15'b000000000000101, 1, 1'b0);

    // Scenario 3: empty payload
    do_frame("s3", 2'b01, 4'd0, 15'h7FFF, 1, 1'b0);

    // Scenario 4: clkEn alternating; start seen only on clkEn=0 is ignored
    alt = 1'b1;
    if (clkEn !== 1'b0) step();
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle($sformatf("s4_ign%0d", i));
      step();
    end
    do_frame("s4", 2'b11, 4'd15, 15'h5555, 2, 1'b0);
    alt   = 1'b0;
    clkEn = 1'b1;
    step();

    // Scenario 5: inputs disturbed while busy
    do_frame("s5", 2'b10, 4'd3, 15'b000000000000101, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle($sformatf("s5_quiet%0d", i));
    end

    // Scenario 6: reset mid-DATA, then a clean frame
    bus_if.start   = 1'b1;
    bus_if.port    = 2'b10;
    bus_if.NumData = 4'd15;
    bus_if.data_in = 15'h2D4B;
    step();
    bus_if.start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("s6_busy_mid", bus_if.busy, 1'b1);
    rst = 1'b0;
    step();
    check_idle("s6_abort");
    rst = 1'b1;
    step();
    check_idle("s6_post");
    do_frame("s6b", 2'b01, 4'd5, 15'h1A3C, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
